cmd_frame_decode: RTL and testbench
===================================

CMD_FRAME_DECODE -- requirements
Module: cmd_frame_decode

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 3: address bytes per frame; ADDR_W = 8*ADDR_BYTES.
REQ-002 SHALL have parameter MAX_LEN, default 255: largest accepted burst length (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 500000: allowed sclk cycles between bytes within a frame.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: sclk in 1, the single clock; srst_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports uart_flag in 1 (received-byte strobe) and uart_data in 8 (received byte).
REQ-006 SHALL have ports wfifo_din out 8, wfifo_wr_en out 1, wfifo_full in 1 and wfifo_clr out 1 (write-FIFO flush pulse).
REQ-007 SHALL have ports wr_trig out 1, wr_addr out ADDR_W, wr_len out 8, rd_trig out 1, rd_addr out ADDR_W, rd_len out 8, sdram_busy in 1.
REQ-008 SHALL have ports rfifo_empty in 1, rfifo_rd_en out 1, rfifo_dout in 8 (1-cycle read latency).
REQ-009 SHALL have ports tx_trig out 1, tx_data out 8, tx_busy in 1, and frame_err out 1 (error pulse).

Function
REQ-010 SHALL parse frames of the form header, ADDR_BYTES address bytes MSB first, length byte L, then L data bytes for writes only; header 0x55 = write, 0xAA = read.
REQ-011 SHALL use parse FSM states IDLE, ADDR, LEN, DATA, TRIG; bytes are consumed only on cycles where uart_flag=1.
REQ-012 SHALL, in IDLE, on any header other than 0x55/0xAA, pulse frame_err for 1 cycle and remain in IDLE.
REQ-013 SHALL shift address bytes into an ADDR_W register and go to LEN after the ADDR_BYTES-th byte.
REQ-014 SHALL, in LEN, reject L=0 or L>MAX_LEN: pulse frame_err, go to IDLE, issue no trigger.
REQ-015 SHALL, for a write, on each DATA byte drive wfifo_din=uart_data and wfifo_wr_en=1 in the same cycle as uart_flag, then go to TRIG after the L-th byte.
REQ-016 SHALL, for a read, go from LEN directly to TRIG.
REQ-017 SHALL, in TRIG, wait while sdram_busy=1; on the first cycle with sdram_busy=0, pulse wr_trig or rd_trig for exactly 1 cycle and return to IDLE.
REQ-018 SHALL hold wr_addr/wr_len (or rd_addr/rd_len) stable from the trigger cycle until the next frame reaches TRIG.
REQ-019 SHALL count idle cycles in ADDR, LEN and DATA; at TIMEOUT_CYC without uart_flag, pulse frame_err, go to IDLE, and pulse wfifo_clr if any DATA byte was written.
REQ-020 SHALL treat uart_flag arriving in the same cycle as timeout expiry as a received byte: the byte is accepted and the counter cleared.
REQ-021 SHALL, on a DATA byte arriving while wfifo_full=1, drop the byte, pulse frame_err and wfifo_clr, and go to IDLE.
REQ-022 SHALL ignore uart_flag while in TRIG (the byte is discarded).
REQ-023 SHALL run an independent drain FSM with states D_IDLE, D_RD, D_SEND, D_WAIT.
REQ-024 SHALL, in D_IDLE, when rfifo_empty=0 and tx_busy=0, pulse rfifo_rd_en for 1 cycle and go to D_RD.
REQ-025 SHALL, in D_RD, go to D_SEND; in D_SEND, drive tx_data=rfifo_dout, pulse tx_trig for 1 cycle and go to D_WAIT.
REQ-026 SHALL, in D_WAIT, skip one cycle and then wait for tx_busy=0 before returning to D_IDLE; at most one byte is in flight.
REQ-027 SHALL keep the parse and drain FSMs fully concurrent; neither stalls the other.

Reset
REQ-028 SHALL, while srst_n=0, force both FSMs to IDLE/D_IDLE and clear all counters and registers.
REQ-029 SHALL reset all outputs to 0, including addresses, lengths and tx_data.
REQ-030 SHALL discard any partial frame on reset mid-frame without pulsing wfifo_clr or frame_err; the external FIFO is reset by the same srst_n.

Verification
REQ-031 SHALL pass: bytes 55 00 01 20 03 A1 B2 C3, sdram_busy=0 -> 3 wfifo_wr_en pulses with A1,B2,C3, then 1 wr_trig with wr_addr=0x000120, wr_len=3.
REQ-032 SHALL pass: bytes AA 00 00 10 04 with sdram_busy=1 for 20 cycles -> rd_trig asserted once, on the first cycle sdram_busy=0, with rd_addr=0x000010, rd_len=4.
REQ-033 SHALL pass: bytes 55 00 00 00 02 11, then silence for TIMEOUT_CYC -> frame_err and wfifo_clr pulse once, no wr_trig, FSM in IDLE.
REQ-034 SHALL pass: header 0x3C, then length byte 0x00 in a valid read frame -> one frame_err pulse each, no triggers.
REQ-035 SHALL pass: rfifo holding 5 bytes, tx_busy high 100 cycles after each tx_trig -> 5 tx_trig pulses in FIFO order, never while tx_busy=1.
REQ-036 SHALL pass: srst_n pulsed low during DATA of a write frame -> all outputs 0 and no trigger; the next valid frame completes correctly.

Source files
------------

// File: rtl/cmd_frame_decode.sv
// Byte-stream command decoder: parses write/read frames into FIFO writes and
// SDRAM triggers, and independently drains a read FIFO out to a UART transmitter.
module cmd_frame_decode #(
  parameter int unsigned ADDR_BYTES  = 3,
  parameter int unsigned MAX_LEN     = 255,
  parameter int unsigned TIMEOUT_CYC = 500000,
  localparam int unsigned ADDR_W     = 8 * ADDR_BYTES
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic              uart_flag,
  input  logic [7:0]        uart_data,
  output logic [7:0]        wfifo_din,
  output logic              wfifo_wr_en,
  input  logic              wfifo_full,
  output logic              wfifo_clr,
  output logic              wr_trig,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_len,
  output logic              rd_trig,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              sdram_busy,
  input  logic              rfifo_empty,
  output logic              rfifo_rd_en,
  input  logic [7:0]        rfifo_dout,
  output logic              tx_trig,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StTrig} pstate_e;
  typedef enum logic [1:0] {DIdle, DRd, DSend, DWait} dstate_e;

  pstate_e           r_pst, w_pst_d;
  logic              r_is_wr, w_is_wr_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [7:0]        r_cnt, w_cnt_d;
  logic [7:0]        r_len, w_len_d;
  logic [TW-1:0]     r_tmo, w_tmo_d;
  logic              r_dirty, w_dirty_d;
  logic              r_ferr, w_ferr_d;
  logic              r_clr, w_clr_d;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_d;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_d;
  logic [7:0]        r_wr_len, w_wr_len_d;
  logic [7:0]        r_rd_len, w_rd_len_d;

  dstate_e           r_dst, w_dst_d;
  logic              r_skip, w_skip_d;
  logic [7:0]        r_tx_data, w_tx_data_d;

  always_comb begin
    w_pst_d     = r_pst;
    w_is_wr_d   = r_is_wr;
    w_addr_d    = r_addr;
    w_cnt_d     = r_cnt;
    w_len_d     = r_len;
    w_tmo_d     = r_tmo;
    w_dirty_d   = r_dirty;
    w_ferr_d    = 1'b0;
    w_clr_d     = 1'b0;
    w_wr_addr_d = r_wr_addr;
    w_wr_len_d  = r_wr_len;
    w_rd_addr_d = r_rd_addr;
    w_rd_len_d  = r_rd_len;
    wfifo_wr_en = 1'b0;
    wfifo_din   = 8'h00;
    wr_trig     = 1'b0;
    rd_trig     = 1'b0;

    unique case (r_pst)
      StIdle: begin
        w_tmo_d   = '0;
        w_cnt_d   = 8'd0;
        w_dirty_d = 1'b0;
        if (uart_flag) begin
          if (uart_data == 8'h55 || uart_data == 8'hAA) begin
            w_is_wr_d = (uart_data == 8'h55);
            w_pst_d   = StAddr;
          end else begin
            w_ferr_d = 1'b1;
          end
        end
      end
      StAddr: begin
        if (uart_flag) begin
          w_addr_d = (r_addr << 8) | ADDR_W'(uart_data);
          if (r_cnt == 8'(ADDR_BYTES - 1)) begin
            w_cnt_d = 8'd0;
            w_pst_d = StLen;
          end else begin
            w_cnt_d = r_cnt + 8'd1;
          end
        end
      end
      StLen: begin
        if (uart_flag) begin
          if (uart_data == 8'd0 || 32'(uart_data) > MAX_LEN) begin
            w_ferr_d = 1'b1;
            w_pst_d  = StIdle;
          end else if (r_is_wr) begin
            w_len_d = uart_data;
            w_pst_d = StData;
          end else begin
            w_rd_addr_d = r_addr;
            w_rd_len_d  = uart_data;
            w_pst_d     = StTrig;
          end
        end
      end
      StData: begin
        if (uart_flag) begin
          if (wfifo_full) begin
            w_ferr_d = 1'b1;
            w_clr_d  = 1'b1;
            w_pst_d  = StIdle;
          end else begin
            wfifo_wr_en = 1'b1;
            wfifo_din   = uart_data;
            w_dirty_d   = 1'b1;
            w_cnt_d     = r_cnt + 8'd1;
            if (r_cnt + 8'd1 == r_len) begin
              w_wr_addr_d = r_addr;
              w_wr_len_d  = r_len;
              w_pst_d     = StTrig;
            end
          end
        end
      end
      StTrig: begin
        // Bytes arriving here are dropped on purpose.
        if (!sdram_busy) begin
          wr_trig = r_is_wr;
          rd_trig = !r_is_wr;
          w_pst_d = StIdle;
        end
      end
      default: w_pst_d = StIdle;
    endcase

    // Inter-byte timeout; a byte landing on the expiry cycle wins.
    if (r_pst == StAddr || r_pst == StLen || r_pst == StData) begin
      if (uart_flag) begin
        w_tmo_d = '0;
      end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
        w_pst_d  = StIdle;
        w_ferr_d = 1'b1;
        w_clr_d  = r_dirty;
      end else begin
        w_tmo_d = r_tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_pst     <= StIdle;
      r_is_wr   <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= 8'd0;
      r_len     <= 8'd0;
      r_tmo     <= '0;
      r_dirty   <= 1'b0;
      r_ferr    <= 1'b0;
      r_clr     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_len  <= 8'd0;
      r_rd_addr <= '0;
      r_rd_len  <= 8'd0;
    end else begin
      r_pst     <= w_pst_d;
      r_is_wr   <= w_is_wr_d;
      r_addr    <= w_addr_d;
      r_cnt     <= w_cnt_d;
      r_len     <= w_len_d;
      r_tmo     <= w_tmo_d;
      r_dirty   <= w_dirty_d;
      r_ferr    <= w_ferr_d;
      r_clr     <= w_clr_d;
      r_wr_addr <= w_wr_addr_d;
      r_wr_len  <= w_wr_len_d;
      r_rd_addr <= w_rd_addr_d;
      r_rd_len  <= w_rd_len_d;
    end
  end

  assign frame_err = r_ferr;
  assign wfifo_clr = r_clr;
  assign wr_addr   = r_wr_addr;
  assign wr_len    = r_wr_len;
  assign rd_addr   = r_rd_addr;
  assign rd_len    = r_rd_len;

  // Drain FSM: one byte in flight; D_WAIT skips a cycle so tx_busy can rise.
  always_comb begin
    w_dst_d     = r_dst;
    w_skip_d    = r_skip;
    w_tx_data_d = r_tx_data;
    rfifo_rd_en = 1'b0;
    tx_trig     = 1'b0;
    unique case (r_dst)
      DIdle: begin
        if (srst_n && !rfifo_empty && !tx_busy) begin
          rfifo_rd_en = 1'b1;
          w_dst_d     = DRd;
        end
      end
      DRd: begin
        w_tx_data_d = rfifo_dout;
        w_dst_d     = DSend;
      end
      DSend: begin
        tx_trig  = 1'b1;
        w_skip_d = 1'b1;
        w_dst_d  = DWait;
      end
      DWait: begin
        if (r_skip) begin
          w_skip_d = 1'b0;
        end else if (!tx_busy) begin
          w_dst_d = DIdle;
        end
      end
      default: w_dst_d = DIdle;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_dst     <= DIdle;
      r_skip    <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_dst     <= w_dst_d;
      r_skip    <= w_skip_d;
      r_tx_data <= w_tx_data_d;
    end
  end

  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_cmd_frame_decode.sv
// Directed bench for cmd_frame_decode: frame parsing, errors, timeout,
// mid-frame reset and the read-FIFO drain to the transmitter.
module tb_cmd_frame_decode;

  localparam int unsigned AB = 3;
  localparam int unsigned ML = 16;
  localparam int unsigned TC = 60;

  logic        sclk = 1'b0;
  logic        srst_n = 1'b0;
  logic        uart_flag = 1'b0;
  logic [7:0]  uart_data = 8'h00;
  logic [7:0]  wfifo_din;
  logic        wfifo_wr_en;
  logic        wfifo_full = 1'b0;
  logic        wfifo_clr;
  logic        wr_trig, rd_trig, tx_trig, rfifo_rd_en, frame_err, tx_busy, rfifo_empty;
  logic [23:0] wr_addr, rd_addr;
  logic [7:0]  wr_len, rd_len, tx_data;
  logic        sdram_busy = 1'b0;
  logic [7:0]  rfifo_dout = 8'h00;

  always #5 sclk = ~sclk;

  cmd_frame_decode #(.ADDR_BYTES(AB), .MAX_LEN(ML), .TIMEOUT_CYC(TC)) u_dut (
    .sclk(sclk), .srst_n(srst_n), .uart_flag(uart_flag), .uart_data(uart_data),
    .wfifo_din(wfifo_din), .wfifo_wr_en(wfifo_wr_en), .wfifo_full(wfifo_full),
    .wfifo_clr(wfifo_clr), .wr_trig(wr_trig), .wr_addr(wr_addr), .wr_len(wr_len),
    .rd_trig(rd_trig), .rd_addr(rd_addr), .rd_len(rd_len), .sdram_busy(sdram_busy),
    .rfifo_empty(rfifo_empty), .rfifo_rd_en(rfifo_rd_en), .rfifo_dout(rfifo_dout),
    .tx_trig(tx_trig), .tx_data(tx_data), .tx_busy(tx_busy), .frame_err(frame_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read FIFO and transmitter models.
  logic [7:0] rmem [8];
  int fill = 0;
  int rptr = 0;
  int tcnt = 0;
  assign rfifo_empty = (rptr == fill);
  assign tx_busy     = (tcnt != 0);

  always @(posedge sclk) begin
    if (rfifo_rd_en) begin
      rfifo_dout <= rmem[rptr[2:0]];
      rptr       <= rptr + 1;
    end
    if (tx_trig) tcnt <= 100;
    else if (tcnt != 0) tcnt <= tcnt - 1;
  end

  // Output event monitor.
  int c_wen = 0, c_wt = 0, c_rt = 0, c_fe = 0, c_cl = 0, c_tx = 0;
  logic [7:0] wlog [64];
  logic [7:0] tlog [16];

  always @(negedge sclk) begin
    if (wfifo_wr_en) begin
      wlog[c_wen[5:0]] <= wfifo_din;
      c_wen <= c_wen + 1;
    end
    if (wr_trig) c_wt <= c_wt + 1;
    if (rd_trig) c_rt <= c_rt + 1;
    if (frame_err) c_fe <= c_fe + 1;
    if (wfifo_clr) c_cl <= c_cl + 1;
    if (tx_trig) begin
      tlog[c_tx[3:0]] <= tx_data;
      c_tx <= c_tx + 1;
      check("tx_trig_while_busy", {31'd0, tx_busy}, 32'd0);
    end
  end

  int b_wen, b_wt, b_rt, b_fe, b_cl, b_tx;
  task automatic snap();
    b_wen = c_wen; b_wt = c_wt; b_rt = c_rt; b_fe = c_fe; b_cl = c_cl; b_tx = c_tx;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap = 2);
    uart_data = b;
    uart_flag = 1'b1;
    @(posedge sclk);
    #1;
    uart_flag = 1'b0;
    idle(gap);
  endtask

  task automatic send_head(input logic [7:0] hdr, input logic [23:0] a, input logic [7:0] len);
    send_byte(hdr);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(len);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rmem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    check("rst_wr_addr", {8'd0, wr_addr}, 32'd0);
    check("rst_rd_addr", {8'd0, rd_addr}, 32'd0);
    check("rst_wr_len", {24'd0, wr_len}, 32'd0);
    check("rst_rd_len", {24'd0, rd_len}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_pulses", {26'd0, wr_trig, rd_trig, tx_trig, frame_err, wfifo_clr, wfifo_wr_en},
          32'd0);
    @(posedge sclk);
    #1;
    srst_n = 1'b1;
    idle(2);

    // Write frame
    snap();
    send_head(8'h55, 24'h000120, 8'd3);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    idle(3);
    check("wr_wen_count", c_wen - b_wen, 3);
    check("wr_data0", {24'd0, wlog[b_wen]}, 32'hA1);
    check("wr_data1", {24'd0, wlog[b_wen + 1]}, 32'hB2);
    check("wr_data2", {24'd0, wlog[b_wen + 2]}, 32'hC3);
    check("wr_trig_count", c_wt - b_wt, 1);
    check("wr_addr", {8'd0, wr_addr}, 32'h000120);
    check("wr_len", {24'd0, wr_len}, 32'd3);
    check("wr_no_err", c_fe - b_fe, 0);

    // Read frame held off by sdram_busy
    snap();
    sdram_busy = 1'b1;
    send_head(8'hAA, 24'h000010, 8'd4);
    idle(20);
    check("rd_held_off", c_rt - b_rt, 0);
    sdram_busy = 1'b0;
    @(negedge sclk);
    check("rd_trig_first_free", {31'd0, rd_trig}, 32'd1);
    idle(3);
    check("rd_trig_count", c_rt - b_rt, 1);
    check("rd_addr", {8'd0, rd_addr}, 32'h000010);
    check("rd_len", {24'd0, rd_len}, 32'd4);
    check("wr_addr_held", {8'd0, wr_addr}, 32'h000120);

    // Timeout mid DATA
    snap();
    send_head(8'h55, 24'h000000, 8'd2);
    send_byte(8'h11, 0);
    idle(TC - 5);
    check("tmo_early", c_fe - b_fe, 0);
    idle(20);
    check("tmo_err", c_fe - b_fe, 1);
    check("tmo_clr", c_cl - b_cl, 1);
    check("tmo_no_trig", c_wt - b_wt, 0);
    check("tmo_wen", c_wen - b_wen, 1);

    // Bad header, zero and oversized length, then max length accepted
    snap();
    send_byte(8'h3C);
    check("bad_hdr_err", c_fe - b_fe, 1);
    send_head(8'hAA, 24'h000010, 8'd0);
    check("len0_err", c_fe - b_fe, 2);
    send_head(8'hAA, 24'h000010, 8'(ML + 1));
    check("len_big_err", c_fe - b_fe, 3);
    check("len_err_no_trig", (c_rt - b_rt) + (c_wt - b_wt), 0);
    send_head(8'hAA, 24'h123456, 8'(ML));
    idle(2);
    check("len_max_trig", c_rt - b_rt, 1);
    check("len_max_addr", {8'd0, rd_addr}, 32'h123456);
    check("len_max_len", {24'd0, rd_len}, ML);

    // Bytes landing exactly on the timeout expiry cycle are accepted
    snap();
    send_byte(8'h55);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h02, TC - 1);
    send_byte(8'hD1, TC - 1);
    send_byte(8'hD2);
    idle(2);
    check("edge_no_err", c_fe - b_fe, 0);
    check("edge_trig", c_wt - b_wt, 1);
    check("edge_addr", {8'd0, wr_addr}, 32'h000040);
    check("edge_data1", {24'd0, wlog[b_wen + 1]}, 32'hD2);

    // DATA byte into a full write FIFO
    snap();
    send_head(8'h55, 24'h000050, 8'd2);
    wfifo_full = 1'b1;
    send_byte(8'h77);
    wfifo_full = 1'b0;
    check("full_err", c_fe - b_fe, 1);
    check("full_clr", c_cl - b_cl, 1);
    check("full_dropped", c_wen - b_wen, 0);
    check("full_no_trig", c_wt - b_wt, 0);

    // Bytes arriving in TRIG are ignored
    snap();
    sdram_busy = 1'b1;
    send_head(8'hAA, 24'h000001, 8'd1);
    send_byte(8'h55);
    sdram_busy = 1'b0;
    idle(2);
    send_head(8'hAA, 24'h000002, 8'd1);
    idle(2);
    check("trig_ignore_count", c_rt - b_rt, 2);
    check("trig_ignore_addr", {8'd0, rd_addr}, 32'h000002);
    check("trig_ignore_err", c_fe - b_fe, 0);

    // Drain five bytes while a write frame is parsed concurrently
    snap();
    rmem[0] = 8'h31; rmem[1] = 8'h42; rmem[2] = 8'h53; rmem[3] = 8'h64; rmem[4] = 8'h75;
    fill = 5;
    send_head(8'h55, 24'h000009, 8'd1);
    send_byte(8'h66);
    check("conc_wr_trig", c_wt - b_wt, 1);
    for (int i = 0; i < 800 && (c_tx - b_tx) < 5; i++) @(posedge sclk);
    #1;
    check("drain_count", c_tx - b_tx, 5);
    for (int i = 0; i < 5; i++) check("drain_order", {24'd0, tlog[b_tx + i]}, {24'd0, rmem[i]});
    idle(120);
    check("drain_no_extra", c_tx - b_tx, 5);

    // Reset during DATA of a write frame
    snap();
    send_head(8'h55, 24'h000033, 8'd4);
    send_byte(8'hE1);
    send_byte(8'hE2);
    srst_n = 1'b0;
    @(negedge sclk);
    check("mid_rst_wr_addr", {8'd0, wr_addr}, 32'd0);
    check("mid_rst_rd_addr", {8'd0, rd_addr}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_pulses", {29'd0, frame_err, wfifo_clr, wr_trig}, 32'd0);
    idle(3);
    srst_n = 1'b1;
    idle(3);
    check("mid_rst_no_err", (c_fe - b_fe) + (c_cl - b_cl), 0);
    check("mid_rst_no_trig", c_wt - b_wt, 0);
    send_head(8'h55, 24'h000007, 8'd1);
    send_byte(8'h5A);
    check("post_rst_trig", c_wt - b_wt, 1);
    check("post_rst_addr", {8'd0, wr_addr}, 32'h000007);
    check("post_rst_len", {24'd0, wr_len}, 32'd1);
    check("post_rst_data", {24'd0, wlog[c_wen - 1]}, 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
